// File: rtl/qsys_ram_pkg.sv
// Shared constants and helpers for the dual-port pipelined RAM.
// merge_bytes is the one definition of a byte-lane merge, used by the array write and the s2 forward path.
package qsys_ram_pkg;

    localparam int BYTE_W = 8;

    function automatic int rd_latency(input int outreg);
        return (outreg != 0) ? 2 : 1;
    endfunction

    function automatic logic [BYTE_W-1:0] merge_bytes(
        input logic [BYTE_W-1:0] old_byte,
        input logic [BYTE_W-1:0] new_byte,
        input logic              be
    );
        return be ? new_byte : old_byte;
    endfunction

endpackage

// File: rtl/qsys_ram_sdp_core.sv
// Byte-enabled simple-dual-port storage: port a writes/reads, port b reads only.
// Registered reads, no reset on storage; a same-address read on port b returns the old word.
module qsys_ram_sdp_core
    import qsys_ram_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4096,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     ce,
    input  logic                     we,
    input  logic                     re_a,
    input  logic                     re_b,
    input  logic [ADDR_W-1:0]        addr_a,
    input  logic [ADDR_W-1:0]        addr_b,
    input  logic [DATA_W/BYTE_W-1:0] be,
    input  logic [DATA_W-1:0]        wdata,
    output logic [DATA_W-1:0]        q_a,
    output logic [DATA_W-1:0]        q_b
);

    localparam int LANES = DATA_W / BYTE_W;

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (ce) begin
            if (we) begin
                for (int i = 0; i < LANES; i++) begin
                    mem[addr_a][i*BYTE_W +: BYTE_W] <= merge_bytes(mem[addr_a][i*BYTE_W +: BYTE_W],
                                                                   wdata[i*BYTE_W +: BYTE_W], be[i]);
                end
            end
            if (re_a) q_a <= mem[addr_a];
            if (re_b) q_b <= mem[addr_b];
        end
    end

endmodule

// File: rtl/qsys_ram_dp_pipelined.sv
// Two-port Avalon-MM RAM: s1 read/write with byte enables, s2 read-only, pipelined readdatavalid.
// Handshake: a request is accepted in the cycle it is presented while en=1; data returns with valid L en-cycles later.
module qsys_ram_dp_pipelined
    import qsys_ram_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 4096,
    parameter int ADDR_W  = $clog2(DEPTH),
    parameter int OUTREG  = 0,
    parameter int FORWARD = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     reset_req,
    input  logic                     clken,
    input  logic                     s1_chipselect,
    input  logic [ADDR_W-1:0]        s1_address,
    input  logic                     s1_read,
    input  logic                     s1_write,
    input  logic [DATA_W/BYTE_W-1:0] s1_byteenable,
    input  logic [DATA_W-1:0]        s1_writedata,
    output logic [DATA_W-1:0]        s1_readdata,
    output logic                     s1_readdatavalid,
    input  logic                     s2_chipselect,
    input  logic [ADDR_W-1:0]        s2_address,
    input  logic                     s2_read,
    output logic [DATA_W-1:0]        s2_readdata,
    output logic                     s2_readdatavalid
);

    localparam int LANES = DATA_W / BYTE_W;
    localparam int LAT   = rd_latency(OUTREG);

    logic en, s1_wr, s1_rd, s2_rd, collide;
    logic [DATA_W-1:0] q_a, q_b, s2_fwd, s1_d1, s2_d1;

    assign en      = clken & ~reset_req;
    assign s1_wr   = en & ~reset & s1_chipselect & s1_write;
    assign s1_rd   = en & ~reset & s1_chipselect & s1_read & ~s1_write;
    assign s2_rd   = en & ~reset & s2_chipselect & s2_read;
    assign collide = s2_rd & s1_wr & (s1_address == s2_address);

    qsys_ram_sdp_core #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_core (
        .clk    (clk),
        .ce     (en),
        .we     (s1_wr),
        .re_a   (s1_rd),
        .re_b   (s2_rd),
        .addr_a (s1_address),
        .addr_b (s2_address),
        .be     (s1_byteenable),
        .wdata  (s1_writedata),
        .q_a    (q_a),
        .q_b    (q_b)
    );

    // The collision operands are captured on acceptance; the merge lands on q_b (the old word) one stage later.
    logic s1_v1, s2_v1, s1_live, s2_live, col_r;
    logic [DATA_W-1:0] fwd_data_r;
    logic [LANES-1:0]  fwd_be_r;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_v1   <= 1'b0;
            s2_v1   <= 1'b0;
            s1_live <= 1'b0;
            s2_live <= 1'b0;
            col_r   <= 1'b0;
        end else if (en) begin
            s1_v1 <= s1_rd;
            s2_v1 <= s2_rd;
            if (s1_rd) s1_live <= 1'b1;
            if (s2_rd) begin
                s2_live    <= 1'b1;
                col_r      <= collide;
                fwd_data_r <= s1_writedata;
                fwd_be_r   <= s1_byteenable;
            end
        end
    end

    always_comb begin
        s2_fwd = q_b;
        for (int i = 0; i < LANES; i++) begin
            s2_fwd[i*BYTE_W +: BYTE_W] = merge_bytes(q_b[i*BYTE_W +: BYTE_W],
                                                     fwd_data_r[i*BYTE_W +: BYTE_W], fwd_be_r[i]);
        end
    end

    // Storage has no reset, so the "live" flags force zero data until the first read after reset.
    assign s1_d1 = s1_live ? q_a : '0;
    assign s2_d1 = !s2_live ? '0 : ((FORWARD != 0 && col_r) ? s2_fwd : q_b);

    generate
        if (LAT == 2) begin : g_outreg
            logic [DATA_W-1:0] s1_q, s2_q;
            logic s1_v2, s2_v2;

            always_ff @(posedge clk) begin
                if (reset) begin
                    s1_q  <= '0;
                    s2_q  <= '0;
                    s1_v2 <= 1'b0;
                    s2_v2 <= 1'b0;
                end else if (en) begin
                    s1_v2 <= s1_v1;
                    s2_v2 <= s2_v1;
                    if (s1_v1) s1_q <= s1_d1;
                    if (s2_v1) s2_q <= s2_d1;
                end
            end

            assign s1_readdata      = s1_q;
            assign s2_readdata      = s2_q;
            assign s1_readdatavalid = s1_v2;
            assign s2_readdatavalid = s2_v2;
        end else begin : g_direct
            assign s1_readdata      = s1_d1;
            assign s2_readdata      = s2_d1;
            assign s1_readdatavalid = s1_v1;
            assign s2_readdatavalid = s2_v1;
        end
    endgenerate

endmodule

// File: tb/tb_qsys_ram_dp_pipelined.sv
// Directed bench driving two RAM instances in lockstep: defaults (L=1, forward) and OUTREG=1/FORWARD=0 (L=2, old data).
// Valid beats are logged per stream (0=d0.s1, 1=d0.s2, 2=d1.s1, 3=d1.s2) and matched against hand-computed beats.
module tb_qsys_ram_dp_pipelined;

    logic        clk = 1'b0;
    logic        reset, reset_req, clken;
    logic        s1_cs, s1_rd, s1_wr, s2_cs, s2_rd;
    logic [11:0] s1_addr, s2_addr;
    logic [3:0]  s1_be;
    logic [31:0] s1_wd;
    logic [31:0] s1_rdata0, s2_rdata0, s1_rdata1, s2_rdata1;
    logic        s1_rdv0, s2_rdv0, s1_rdv1, s2_rdv1;

    int cyc = 0;
    int n_checks = 0;
    int n_errors = 0;
    int k, k2, k3;

    typedef struct {
        int          s;
        logic [31:0] d;
        int          c;
    } ev_t;
    ev_t ev_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    qsys_ram_dp_pipelined u_dut0 (
        .clk(clk), .reset(reset), .reset_req(reset_req), .clken(clken),
        .s1_chipselect(s1_cs), .s1_address(s1_addr), .s1_read(s1_rd), .s1_write(s1_wr),
        .s1_byteenable(s1_be), .s1_writedata(s1_wd), .s1_readdata(s1_rdata0),
        .s1_readdatavalid(s1_rdv0), .s2_chipselect(s2_cs), .s2_address(s2_addr),
        .s2_read(s2_rd), .s2_readdata(s2_rdata0), .s2_readdatavalid(s2_rdv0)
    );

    qsys_ram_dp_pipelined #(.OUTREG(1), .FORWARD(0)) u_dut1 (
        .clk(clk), .reset(reset), .reset_req(reset_req), .clken(clken),
        .s1_chipselect(s1_cs), .s1_address(s1_addr), .s1_read(s1_rd), .s1_write(s1_wr),
        .s1_byteenable(s1_be), .s1_writedata(s1_wd), .s1_readdata(s1_rdata1),
        .s1_readdatavalid(s1_rdv1), .s2_chipselect(s2_cs), .s2_address(s2_addr),
        .s2_read(s2_rd), .s2_readdata(s2_rdata1), .s2_readdatavalid(s2_rdv1)
    );

    // A valid beat counts only in a cycle whose closing edge has en=1.
    always @(negedge clk) begin
        if (clken && !reset_req) begin
            if (s1_rdv0) ev_q.push_back('{s: 0, d: s1_rdata0, c: cyc});
            if (s2_rdv0) ev_q.push_back('{s: 1, d: s2_rdata0, c: cyc});
            if (s1_rdv1) ev_q.push_back('{s: 2, d: s1_rdata1, c: cyc});
            if (s2_rdv1) ev_q.push_back('{s: 3, d: s2_rdata1, c: cyc});
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        s1_cs = 1'b0; s1_rd = 1'b0; s1_wr = 1'b0; s1_be = 4'h0; s1_wd = 32'h0; s1_addr = 12'h0;
        s2_cs = 1'b0; s2_rd = 1'b0; s2_addr = 12'h0;
    endtask

    task automatic do_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] be);
        s1_cs = 1'b1; s1_wr = 1'b1; s1_addr = a; s1_wd = d; s1_be = be;
        tick();
        idle();
    endtask

    task automatic expect_ev(input int s, input logic [31:0] d, input int c);
        int idx;
        idx = -1;
        for (int i = 0; i < ev_q.size(); i++) begin
            if (idx < 0 && ev_q[i].s == s) idx = i;
        end
        if (idx < 0) begin
            check($sformatf("stream%0d beat@%0d present", s, c), 32'd0, 32'd1);
        end else begin
            check($sformatf("stream%0d beat@%0d data", s, c), ev_q[idx].d, d);
            check($sformatf("stream%0d beat@%0d cycle", s, c), ev_q[idx].c, c);
            ev_q.delete(idx);
        end
    endtask

    task automatic expect_none(input string tag);
        check({tag, " extra valid beats"}, ev_q.size(), 32'd0);
        ev_q.delete();
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, " d0.s1 data"}, s1_rdata0, 32'h0);
        check({tag, " d0.s2 data"}, s2_rdata0, 32'h0);
        check({tag, " d1.s1 data"}, s1_rdata1, 32'h0);
        check({tag, " d1.s2 data"}, s2_rdata1, 32'h0);
        check({tag, " d0.s1 valid"}, {31'b0, s1_rdv0}, 32'h0);
        check({tag, " d0.s2 valid"}, {31'b0, s2_rdv0}, 32'h0);
        check({tag, " d1.s1 valid"}, {31'b0, s1_rdv1}, 32'h0);
        check({tag, " d1.s2 valid"}, {31'b0, s2_rdv1}, 32'h0);
    endtask

    int lat0[4] = '{1, 5, 6, 7};
    int lat1[4] = '{5, 6, 7, 8};

    initial begin
        reset = 1'b1; reset_req = 1'b0; clken = 1'b1;
        idle();
        repeat (3) tick();
        check_zero_outputs("reset");
        reset = 1'b0;
        tick();
        ev_q.delete();

        // Basic write then read, latency 1 vs 2
        do_write(12'd5, 32'hDEADBEEF, 4'hF);
        k = cyc;
        s1_cs = 1'b1; s1_rd = 1'b1; s1_addr = 12'd5;
        tick(); idle(); repeat (4) tick();
        expect_ev(0, 32'hDEADBEEF, k + 1);
        expect_ev(2, 32'hDEADBEEF, k + 2);
        expect_none("basic");

        // Byte lanes: be=0x5 touches bytes 0 and 2
        do_write(12'd7, 32'h11223344, 4'hF);
        do_write(12'd7, 32'hAABBCCDD, 4'h5);
        k = cyc;
        s1_cs = 1'b1; s1_rd = 1'b1; s1_addr = 12'd7;
        s2_cs = 1'b1; s2_rd = 1'b1; s2_addr = 12'd7;
        tick(); idle(); repeat (4) tick();
        expect_ev(0, 32'h11BB33DD, k + 1);
        expect_ev(1, 32'h11BB33DD, k + 1);
        expect_ev(2, 32'h11BB33DD, k + 2);
        expect_ev(3, 32'h11BB33DD, k + 2);
        expect_none("lanes");

        // Collision: full-word, follow-up read, then partial-lane collision
        do_write(12'd9, 32'h00000000, 4'hF);
        k = cyc;
        s1_cs = 1'b1; s1_wr = 1'b1; s1_addr = 12'd9; s1_wd = 32'hCAFEF00D; s1_be = 4'hF;
        s2_cs = 1'b1; s2_rd = 1'b1; s2_addr = 12'd9;
        tick(); idle();
        k2 = cyc;
        s2_cs = 1'b1; s2_rd = 1'b1; s2_addr = 12'd9;
        tick(); idle();
        k3 = cyc;
        s1_cs = 1'b1; s1_wr = 1'b1; s1_addr = 12'd9; s1_wd = 32'h12345678; s1_be = 4'h3;
        s2_cs = 1'b1; s2_rd = 1'b1; s2_addr = 12'd9;
        tick(); idle(); repeat (4) tick();
        expect_ev(1, 32'hCAFEF00D, k + 1);
        expect_ev(1, 32'hCAFEF00D, k2 + 1);
        expect_ev(1, 32'hCAFE5678, k3 + 1);
        expect_ev(3, 32'h00000000, k + 2);
        expect_ev(3, 32'hCAFEF00D, k2 + 2);
        expect_ev(3, 32'hCAFEF00D, k3 + 2);
        expect_none("collision");

        // Stall after the second read: m=0 drops clken, m=1 raises reset_req
        for (int i = 0; i < 4; i++) do_write(12'(i), 32'h10000000 + 32'(i), 4'hF);
        for (int m = 0; m < 2; m++) begin
            k = cyc;
            s2_cs = 1'b1; s2_rd = 1'b1; s2_addr = 12'd0;
            tick();
            s2_addr = 12'd1;
            tick();
            s2_addr = 12'd2;
            if (m == 0) clken = 1'b0; else reset_req = 1'b1;
            repeat (3) tick();
            clken = 1'b1; reset_req = 1'b0;
            tick();
            s2_addr = 12'd3;
            tick();
            idle(); repeat (5) tick();
            for (int i = 0; i < 4; i++) expect_ev(1, 32'h10000000 + 32'(i), k + lat0[i]);
            for (int i = 0; i < 4; i++) expect_ev(3, 32'h10000000 + 32'(i), k + lat1[i]);
            expect_none(m == 0 ? "stall clken" : "stall reset_req");
        end

        // Reset mid-flight; the write presented under reset must be ignored
        k = cyc;
        s1_cs = 1'b1; s1_rd = 1'b1; s1_addr = 12'd5;
        tick(); idle();
        reset = 1'b1;
        s1_cs = 1'b1; s1_wr = 1'b1; s1_addr = 12'd5; s1_wd = 32'h00000000; s1_be = 4'hF;
        tick(); tick();
        reset = 1'b0; idle();
        check_zero_outputs("post-reset");
        expect_ev(0, 32'hDEADBEEF, k + 1);
        expect_none("reset flight");
        k2 = cyc;
        s1_cs = 1'b1; s1_rd = 1'b1; s1_addr = 12'd5;
        tick(); idle(); repeat (4) tick();
        expect_ev(0, 32'hDEADBEEF, k2 + 1);
        expect_ev(2, 32'hDEADBEEF, k2 + 2);
        expect_none("reset contents");

        // Write wins over a simultaneous s1 read; s2 proceeds normally
        k = cyc;
        s1_cs = 1'b1; s1_rd = 1'b1; s1_wr = 1'b1; s1_addr = 12'd11; s1_wd = 32'h5A5A5A5A; s1_be = 4'hF;
        s2_cs = 1'b1; s2_rd = 1'b1; s2_addr = 12'd7;
        tick(); idle(); repeat (4) tick();
        expect_ev(1, 32'h11BB33DD, k + 1);
        expect_ev(3, 32'h11BB33DD, k + 2);
        expect_none("write-wins");
        k2 = cyc;
        s1_cs = 1'b1; s1_rd = 1'b1; s1_addr = 12'd11;
        tick(); idle(); repeat (4) tick();
        expect_ev(0, 32'h5A5A5A5A, k2 + 1);
        expect_ev(2, 32'h5A5A5A5A, k2 + 2);
        expect_none("write-wins readback");
        check("hold d0.s1 data", s1_rdata0, 32'h5A5A5A5A);
        check("hold d1.s1 data", s1_rdata1, 32'h5A5A5A5A);
        check("hold d0.s1 valid", {31'b0, s1_rdv0}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
